// File: rtl/cas_pkg.sv
// Shared constants and FSM state type for the odd-even transposition sorter.
package cas_pkg;

    localparam int unsigned DEF_SNG_WIDTH  = 10;
    localparam int unsigned DEF_NUM_INPUTS = 8;

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        DONE
    } state_t;

endpackage

// File: rtl/cas_cell.sv
// Combinational compare-and-swap of one unsigned element pair; equal values never swap.
module cas_cell #(
    parameter int unsigned SNG_WIDTH = 10
) (
    input  logic [SNG_WIDTH-1:0] lo,
    input  logic [SNG_WIDTH-1:0] hi,
    input  logic                 desc,
    output logic [SNG_WIDTH-1:0] lo_new,
    output logic [SNG_WIDTH-1:0] hi_new
);

    logic [SNG_WIDTH:0] w_diff;
    logic               w_lo_gt;
    logic               w_lo_lt;
    logic               w_swap;

    // Borrow bit of lo-hi gives lo<hi; a non-zero result without borrow gives lo>hi.
    assign w_diff  = {1'b0, lo} - {1'b0, hi};
    assign w_lo_lt = w_diff[SNG_WIDTH];
    assign w_lo_gt = ~w_diff[SNG_WIDTH] & (|w_diff[SNG_WIDTH-1:0]);
    assign w_swap  = desc ? w_lo_lt : w_lo_gt;

    assign lo_new = w_swap ? hi : lo;
    assign hi_new = w_swap ? lo : hi;

endmodule

// File: rtl/oets_sorter.sv
// Iterative odd-even transposition sorter: one phase per cycle, NUM_INPUTS phases,
// then a cycle to register the result before presenting it with a valid/ready handshake.
module oets_sorter
    import cas_pkg::*;
#(
    parameter int unsigned SNG_WIDTH  = DEF_SNG_WIDTH,
    parameter int unsigned NUM_INPUTS = DEF_NUM_INPUTS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_INPUTS*SNG_WIDTH-1:0] in_data,
    input  logic                            in_desc,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_INPUTS*SNG_WIDTH-1:0] out_data
);

    localparam int unsigned         PHASE_W    = $clog2(NUM_INPUTS + 1);
    localparam int unsigned         NUM_PAIRS  = NUM_INPUTS / 2;
    localparam logic [PHASE_W-1:0]  LAST_PHASE = PHASE_W'(NUM_INPUTS);

    if ((NUM_INPUTS < 2) || (NUM_INPUTS % 2 != 0)) begin : g_param_check
        $error("oets_sorter: NUM_INPUTS must be even and >= 2");
    end

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [PHASE_W-1:0]             r_phase;
    logic                           r_desc;
    logic [SNG_WIDTH-1:0]           r_elem [NUM_INPUTS];
    logic [SNG_WIDTH-1:0]           w_even [NUM_INPUTS];
    logic [SNG_WIDTH-1:0]           w_odd  [NUM_INPUTS];
    logic [NUM_INPUTS*SNG_WIDTH-1:0] r_out_data;
    logic                           w_accept;
    logic                           w_sort_done;

    assign w_accept    = (r_state == IDLE) & in_valid;
    assign w_sort_done = (r_phase == LAST_PHASE);
    assign out_data    = r_out_data;

    genvar g;
    for (g = 0; g < NUM_PAIRS; g++) begin : g_even
        cas_cell #(
            .SNG_WIDTH(SNG_WIDTH)
        ) u_cas (
            .lo    (r_elem[2*g]),
            .hi    (r_elem[2*g+1]),
            .desc  (r_desc),
            .lo_new(w_even[2*g]),
            .hi_new(w_even[2*g+1])
        );
    end

    // Odd phases leave the two end elements untouched; with two elements there are no cells.
    assign w_odd[0]            = r_elem[0];
    assign w_odd[NUM_INPUTS-1] = r_elem[NUM_INPUTS-1];
    for (g = 0; g < NUM_PAIRS - 1; g++) begin : g_odd
        cas_cell #(
            .SNG_WIDTH(SNG_WIDTH)
        ) u_cas (
            .lo    (r_elem[2*g+1]),
            .hi    (r_elem[2*g+2]),
            .desc  (r_desc),
            .lo_new(w_odd[2*g+1]),
            .hi_new(w_odd[2*g+2])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = SORT;
                end
            end
            SORT: begin
                if (w_sort_done) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            r_desc     <= 1'b0;
            r_out_data <= '0;
            for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                r_elem[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_desc  <= in_desc;
                r_phase <= '0;
                for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                    r_elem[i] <= in_data[i*SNG_WIDTH +: SNG_WIDTH];
                end
            end else if (r_state == SORT) begin
                if (w_sort_done) begin
                    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                        r_out_data[i*SNG_WIDTH +: SNG_WIDTH] <= r_elem[i];
                    end
                end else begin
                    r_phase <= r_phase + PHASE_W'(1);
                    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
                        r_elem[i] <= r_phase[0] ? w_odd[i] : w_even[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_oets_sorter.sv
// Bench for oets_sorter: vector table, stall/reset/N=2 sequences and random back-to-back sorts.
module tb_oets_sorter;

    localparam int W  = 10;
    localparam int N  = 8;
    localparam int DW = N * W;

    typedef struct packed {
        logic [DW-1:0] din;
        logic          desc;
        logic [DW-1:0] dout;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n8, rst_n2;
    logic          in_valid, in_ready, in_desc, out_valid, out_ready;
    logic [DW-1:0] in_data, out_data;
    logic          in_valid2, in_ready2, in_desc2, out_valid2, out_ready2;
    logic [2*W-1:0] in_data2, out_data2;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] sb_q[$];

    always #5 clk = ~clk;

    oets_sorter #(.SNG_WIDTH(W), .NUM_INPUTS(N)) dut (
        .clk(clk), .rst_n(rst_n8), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_desc(in_desc), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    oets_sorter #(.SNG_WIDTH(W), .NUM_INPUTS(2)) dut2 (
        .clk(clk), .rst_n(rst_n2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .in_desc(in_desc2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_data(out_data2)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [DW-1:0] v;
        v[0*W +: W] = W'(a0); v[1*W +: W] = W'(a1); v[2*W +: W] = W'(a2);
        v[3*W +: W] = W'(a3); v[4*W +: W] = W'(a4); v[5*W +: W] = W'(a5);
        v[6*W +: W] = W'(a6); v[7*W +: W] = W'(a7);
        return v;
    endfunction

    function automatic logic [DW-1:0] ref_sort(input logic [DW-1:0] v, input logic desc);
        int a[N];
        int t;
        logic [DW-1:0] r;
        for (int i = 0; i < N; i++) a[i] = int'(v[i*W +: W]);
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0; j--) begin
                if (desc ? (a[j] > a[j-1]) : (a[j] < a[j-1])) begin
                    t = a[j]; a[j] = a[j-1]; a[j-1] = t;
                end
            end
        end
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(a[i]);
        return r;
    endfunction

    // Called just after a posedge; returns after the accept edge (+1).
    task automatic send8(input logic [DW-1:0] d, input logic desc, input logic [DW-1:0] exp,
                         output int waited);
        in_valid = 1'b1;
        in_data  = d;
        in_desc  = desc;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end else begin
            sb_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_desc  = ~desc;
    endtask

    task automatic recv8(input string nm);
        int k;
        bit seen;
        logic [DW-1:0] exp;
        k    = 0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        chk({nm, "_latency"}, DW'(seen ? k : -1), DW'(N + 1));
        if (seen) begin
            chk({nm, "_in_ready_done"}, DW'(in_ready), DW'(0));
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_sb_empty: got output %h expected none", nm, out_data);
            end else begin
                exp = sb_q.pop_front();
                chk({nm, "_data"}, out_data, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    vec_t tbl[5];
    int   waited;
    logic [DW-1:0] v, vb, exp, held;
    logic d;
    bit   saw_valid;

    initial begin
        tbl[0] = '{din: mk(7, 6, 5, 4, 3, 2, 1, 0), desc: 1'b0, dout: mk(0, 1, 2, 3, 4, 5, 6, 7)};
        tbl[1] = '{din: mk(1023, 0, 512, 512, 3, 1023, 0, 7), desc: 1'b1,
                   dout: mk(1023, 1023, 512, 512, 7, 3, 0, 0)};
        tbl[2] = '{din: mk(5, 5, 5, 5, 5, 5, 5, 5), desc: 1'b0, dout: mk(5, 5, 5, 5, 5, 5, 5, 5)};
        tbl[3] = '{din: mk(0, 1, 2, 3, 4, 5, 6, 7), desc: 1'b1, dout: mk(7, 6, 5, 4, 3, 2, 1, 0)};
        tbl[4] = '{din: mk(1023, 0, 1023, 0, 1, 1022, 2, 3), desc: 1'b0,
                   dout: mk(0, 0, 1, 2, 3, 1022, 1023, 1023)};

        rst_n8 = 1'b0; rst_n2 = 1'b0;
        in_valid = 1'b0; in_data = '1; in_desc = 1'b1; out_ready = 1'b1;
        in_valid2 = 1'b0; in_data2 = '1; in_desc2 = 1'b1; out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n8 = 1'b1; rst_n2 = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", DW'(in_ready), DW'(1));
        chk("reset_out_valid", DW'(out_valid), DW'(0));
        chk("reset_out_data", out_data, '0);
        chk("reset_in_ready_n2", DW'(in_ready2), DW'(1));
        // in_data/in_desc toggling with in_valid=0 must not start a sort.
        repeat (3) begin
            @(posedge clk);
            #1;
            in_data = DW'($urandom());
        end
        @(negedge clk);
        chk("idle_ignore_in_ready", DW'(in_ready), DW'(1));
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            send8(tbl[i].din, tbl[i].desc, tbl[i].dout, waited);
            recv8($sformatf("table%0d", i));
        end

        // Output stall with a second vector already offered.
        out_ready = 1'b0;
        v  = mk(3, 1, 2, 0, 9, 8, 100, 50);
        vb = mk(10, 20, 30, 40, 50, 60, 70, 80);
        send8(v, 1'b0, mk(0, 1, 2, 3, 8, 9, 50, 100), waited);
        recv8("stall");
        held      = out_data;
        in_valid  = 1'b1;
        in_data   = vb;
        in_desc   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_data", c), out_data, mk(0, 1, 2, 3, 8, 9, 50, 100));
            chk($sformatf("stall%0d_in_ready", c), DW'(in_ready), DW'(0));
            chk($sformatf("stall%0d_out_valid", c), DW'(out_valid), DW'(1));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("handshake_in_ready", DW'(in_ready), DW'(0));
        @(posedge clk);
        #1;
        send8(vb, 1'b1, mk(80, 70, 60, 50, 40, 30, 20, 10), waited);
        chk("accept_after_handshake_wait", DW'(waited), DW'(0));
        recv8("after_stall");

        // Reset during the third SORT cycle discards the operation.
        send8(mk(9, 8, 7, 6, 5, 4, 3, 2), 1'b0, mk(2, 3, 4, 5, 6, 7, 8, 9), waited);
        repeat (2) @(posedge clk);
        #1;
        rst_n8 = 1'b0;
        @(posedge clk);
        #1;
        rst_n8 = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("abort_in_ready", DW'(in_ready), DW'(1));
        chk("abort_out_valid", DW'(out_valid), DW'(0));
        chk("abort_out_data", out_data, '0);
        saw_valid = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1;
        end
        chk("abort_no_out_valid", DW'(saw_valid), DW'(0));
        @(posedge clk);
        #1;

        // Two-element instance, both directions.
        for (int s = 0; s < 2; s++) begin
            int k;
            bit seen;
            in_valid2 = 1'b1;
            in_data2  = {10'd2, 10'd5};
            in_desc2  = s[0];
            @(negedge clk);
            chk($sformatf("n2_%0d_in_ready", s), DW'(in_ready2), DW'(1));
            @(posedge clk);
            #1;
            in_valid2 = 1'b0;
            k = 0;
            seen = 0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk);
                k++;
                @(negedge clk);
                if (out_valid2) begin
                    seen = 1;
                    break;
                end
            end
            chk($sformatf("n2_%0d_latency", s), DW'(seen ? k : -1), DW'(3));
            chk($sformatf("n2_%0d_data", s), DW'(out_data2),
                DW'(s == 0 ? {10'd5, 10'd2} : {10'd2, 10'd5}));
            @(posedge clk);
            #1;
        end

        // Random back-to-back traffic.
        for (int n = 0; n < 1000; n++) begin
            for (int e = 0; e < N; e++) v[e*W +: W] = W'($urandom_range(0, 1023));
            d   = 1'($urandom_range(0, 1));
            exp = ref_sort(v, d);
            send8(v, d, exp, waited);
            recv8($sformatf("rand%0d", n));
        end

        chk("sb_drained", DW'(sb_q.size()), DW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/oets_sorter.md
OETS_SORTER -- requirements
Module: oets_sorter

Interface
REQ-001 Parameter SNG_WIDTH, default 10, sets the bit width of each unsigned element.
REQ-002 Parameter NUM_INPUTS, default 8, sets the element count; it SHALL be even and >= 2.
REQ-003 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, is the reset; it SHALL be synchronous and active-low.
REQ-005 Port in_valid, input, 1, marks in_data/in_desc as valid.
REQ-006 Port in_ready, output, 1, means the block accepts a vector this cycle.
REQ-007 Port in_data, input, NUM_INPUTS*SNG_WIDTH, carries the packed elements; element i occupies bits [i*SNG_WIDTH +: SNG_WIDTH].
REQ-008 Port in_desc, input, 1, selects order: 0 = ascending, 1 = descending.
REQ-009 Port out_valid, output, 1, marks out_data as a sorted result.
REQ-010 Port out_ready, input, 1, means the consumer accepts out_data.
REQ-011 Port out_data, output, NUM_INPUTS*SNG_WIDTH, carries the sorted vector, packed as in_data.

Function
REQ-012 The block SHALL be an FSM with states IDLE, SORT and DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready, capture in_data into the element registers, latch in_desc, clear the phase counter and go to SORT.
REQ-014 SORT: in_ready=0, out_valid=0; each cycle SHALL execute exactly one phase, then increment the phase counter.
REQ-015 Even phases (counter bit0=0) SHALL compare-and-swap pairs (0,1),(2,3),...,(N-2,N-1).
REQ-016 Odd phases SHALL compare-and-swap pairs (1,2),...,(N-3,N-2); elements 0 and N-1 SHALL hold.
REQ-017 The block SHALL run exactly NUM_INPUTS phases, then go to DONE.
REQ-018 out_valid SHALL rise NUM_INPUTS+1 clock edges after the accept edge, independent of the data.
REQ-019 Compare rule: treat elements as unsigned and compute a (SNG_WIDTH+1)-bit difference lo-hi. Ascending swaps iff lo>hi; descending swaps iff lo<hi; equal values SHALL never swap.
REQ-020 Element 0 SHALL be the minimum (ascending) or the maximum (descending) of the result.
REQ-021 DONE: out_valid=1, in_ready=0; out_data SHALL stay stable until out_valid&out_ready, then return to IDLE.
REQ-022 in_ready SHALL be 0 on the cycle of the output handshake; a new vector is accepted at the earliest on the next cycle (no bypass).
REQ-023 When NUM_INPUTS=2, odd phases SHALL be no-ops.
REQ-024 The phase counter SHALL be $clog2(NUM_INPUTS+1) bits wide and SHALL not wrap during SORT.
REQ-025 In IDLE, in_data and in_desc SHALL be ignored unless in_valid=1.

Reset
REQ-026 With rst_n=0 at a clock edge, the FSM SHALL go to IDLE, the phase counter to 0, the element registers and out_data to 0, the latched direction to 0, out_valid to 0, and in_ready to 1 from the first cycle after reset.
REQ-027 Reset asserted in SORT or DONE SHALL abort the operation and discard its data; no out_valid pulse SHALL follow.

Structure
REQ-028 A shared package cas_pkg SHALL hold the default SNG_WIDTH and NUM_INPUTS constants and the state enum (IDLE, SORT, DONE).
REQ-029 A combinational sub-module cas_cell, with parameter SNG_WIDTH, inputs lo, hi and desc, and outputs lo_new and hi_new, SHALL implement REQ-019.
REQ-030 oets_sorter SHALL instantiate NUM_INPUTS/2 cas_cell for even phases and NUM_INPUTS/2-1 for odd phases.

Verification
REQ-031 N=8, W=10, asc, in=[7,6,5,4,3,2,1,0], out_ready=1 -> out=[0..7]; out_valid exactly 9 edges after accept.
REQ-032 N=8, desc, in=[1023,0,512,512,3,1023,0,7] -> out=[1023,1023,512,512,7,3,0,0]; equal values do not swap.
REQ-033 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_data stable, in_ready=0, no second accept; a new vector is accepted on the cycle after the handshake.
REQ-034 Assert rst_n=0 in the 3rd SORT cycle -> all outputs return to reset values, in_ready=1 next cycle, no out_valid.
REQ-035 N=2, in=[5,2], asc -> out=[2,5] with latency 3; repeat with desc -> [5,2].
REQ-036 Back-to-back random vectors (1000 samples, N=8) -> every output matches a reference sort in the selected direction.
